// File: rtl/sdio_bus_mem_slave.sv
// Memory-side slave for the SDIO controller's byte-wide DMA bus, driving a single-port sync SRAM.
// Optional address range check: define SDIO_BUS_ADDR_CHK_EN.
module sdio_bus_mem_slave #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 131072,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WAIT_CYC  = 0
) (
    input  logic              bus_clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rd,
    input  logic              bus_wr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic              bus_ready,
    output logic              bus_rdata_ready,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic              err_flag
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RDWAIT = 2'd3;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    localparam logic [1:0] LAT_LOAD  = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    if (RD_LAT < 1 || RD_LAT > 4 || WAIT_CYC > 15 || MEM_DEPTH == 0) begin : g_bad_param
        $error("sdio_bus_mem_slave: parameter out of range");
    end

    logic [1:0]        state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic [1:0]        lat_cnt, lat_cnt_nxt;
    logic              op_rd, op_rd_nxt;
    logic              op_oor, op_oor_nxt;
    logic [ADDR_W-1:0] op_addr, op_addr_nxt;
    logic [DATA_W-1:0] op_wdata, op_wdata_nxt;

    logic              ready_nxt, rdv_nxt, cs_nxt, we_nxt, err_nxt;
    logic [DATA_W-1:0] rdata_nxt, mwdata_nxt;
    logic [ADDR_W-1:0] maddr_nxt;
    logic [15:0]       wr_cnt_nxt, rd_cnt_nxt;
    logic              enter_access, finish_rd;
    logic              addr_oor;

`ifdef SDIO_BUS_ADDR_CHK_EN
    assign addr_oor = (64'(bus_addr) >= 64'(MEM_DEPTH));
`else
    assign addr_oor = 1'b0;
`endif

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        lat_cnt_nxt  = lat_cnt;
        op_rd_nxt    = op_rd;
        op_oor_nxt   = op_oor;
        op_addr_nxt  = op_addr;
        op_wdata_nxt = op_wdata;
        rdv_nxt      = 1'b0;
        cs_nxt       = 1'b0;
        we_nxt       = 1'b0;
        err_nxt      = err_flag;
        rdata_nxt    = bus_rdata;
        maddr_nxt    = mem_addr;
        mwdata_nxt   = mem_wdata;
        wr_cnt_nxt   = wr_cnt;
        rd_cnt_nxt   = rd_cnt;
        enter_access = 1'b0;
        finish_rd    = 1'b0;

        case (state)
            IDLE: begin
                if (bus_rd || bus_wr) begin
                    op_rd_nxt    = bus_rd;
                    op_oor_nxt   = addr_oor;
                    op_addr_nxt  = bus_addr;
                    op_wdata_nxt = bus_wdata;
                    if ((bus_rd && bus_wr) || addr_oor) begin
                        err_nxt = 1'b1;
                    end
                    if (WAIT_CYC > 0) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        enter_access = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    enter_access = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ACCESS: begin
                if (!op_rd) begin
                    state_nxt = IDLE;
                end else if (RD_LAT <= 1) begin
                    finish_rd = 1'b1;
                end else begin
                    state_nxt   = RDWAIT;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            RDWAIT: begin
                if (lat_cnt == 2'd0) begin
                    finish_rd = 1'b1;
                end else begin
                    lat_cnt_nxt = lat_cnt - 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Out-of-range accesses still count but never touch the SRAM.
        if (enter_access) begin
            state_nxt = ACCESS;
            cs_nxt    = !op_oor_nxt;
            we_nxt    = !op_rd_nxt && !op_oor_nxt;
            if (!op_oor_nxt) begin
                maddr_nxt  = op_addr_nxt;
                mwdata_nxt = op_wdata_nxt;
            end
            if (op_rd_nxt) begin
                rd_cnt_nxt = (rd_cnt == 16'hFFFF) ? rd_cnt : rd_cnt + 16'd1;
            end else begin
                wr_cnt_nxt = (wr_cnt == 16'hFFFF) ? wr_cnt : wr_cnt + 16'd1;
            end
        end

        if (finish_rd) begin
            state_nxt = IDLE;
            rdv_nxt   = 1'b1;
            rdata_nxt = op_oor ? {DATA_W{1'b1}} : mem_rdata;
        end

        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge bus_clk) begin
        if (!rstn) begin
            state           <= IDLE;
            wait_cnt        <= 4'd0;
            lat_cnt         <= 2'd0;
            op_rd           <= 1'b0;
            op_oor          <= 1'b0;
            op_addr         <= '0;
            op_wdata        <= '0;
            bus_ready       <= 1'b1;
            bus_rdata_ready <= 1'b0;
            bus_rdata       <= '0;
            mem_cs          <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            wr_cnt          <= 16'd0;
            rd_cnt          <= 16'd0;
            err_flag        <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_cnt_nxt;
            lat_cnt         <= lat_cnt_nxt;
            op_rd           <= op_rd_nxt;
            op_oor          <= op_oor_nxt;
            op_addr         <= op_addr_nxt;
            op_wdata        <= op_wdata_nxt;
            bus_ready       <= ready_nxt;
            bus_rdata_ready <= rdv_nxt;
            bus_rdata       <= rdata_nxt;
            mem_cs          <= cs_nxt;
            mem_we          <= we_nxt;
            mem_addr        <= maddr_nxt;
            mem_wdata       <= mwdata_nxt;
            wr_cnt          <= wr_cnt_nxt;
            rd_cnt          <= rd_cnt_nxt;
            err_flag        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sdio_bus_mem_slave.sv
// Bench for sdio_bus_mem_slave: two instances (default timing, and WAIT_CYC=3/RD_LAT=4) on shared stimulus,
// checked every cycle against a transaction-level timing model plus directed literal checks.
`timescale 1ns/1ps
module tb_sdio_bus_mem_slave;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, bus_rd, bus_wr;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;

    logic          rdy [2], rdv [2], cs [2], we [2], err [2];
    logic [DW-1:0] rdata [2], mwd [2], mrd [2];
    logic [AW-1:0] maddr [2];
    logic [15:0]   wc [2], rc [2];

    // Read-only SRAM contents; mem_addr is held through the read so a combinational lookup suffices.
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (a == 17'h00010) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign mrd[0] = rom(maddr[0]);
    assign mrd[1] = rom(maddr[1]);

    sdio_bus_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1024), .RD_LAT(2), .WAIT_CYC(0)) u_dut_a (
        .bus_clk(clk), .rstn(rstn), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_ready(rdy[0]), .bus_rdata_ready(rdv[0]), .bus_rdata(rdata[0]),
        .mem_cs(cs[0]), .mem_we(we[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]),
        .wr_cnt(wc[0]), .rd_cnt(rc[0]), .err_flag(err[0]));

    sdio_bus_mem_slave #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(131072), .RD_LAT(4), .WAIT_CYC(3)) u_dut_b (
        .bus_clk(clk), .rstn(rstn), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_ready(rdy[1]), .bus_rdata_ready(rdv[1]), .bus_rdata(rdata[1]),
        .mem_cs(cs[1]), .mem_we(we[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]),
        .wr_cnt(wc[1]), .rd_cnt(rc[1]), .err_flag(err[1]));

    function automatic int cfg_w(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int cfg_l(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic oor(input int i, input logic [AW-1:0] a);
`ifdef SDIO_BUS_ADDR_CHK_EN
        return (32'(a) >= ((i == 0) ? 32'd1024 : 32'd131072));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    int n_vec = 0;
    int n_bad = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] got %h want %h at edge %0d", name, inst, got, want, edge_n);
        end
    endtask

    // Transaction model: each accepted request schedules its SRAM edge and completion edge.
    bit            m_busy [2];
    bit            m_isrd [2], m_oor [2];
    int            m_cs_e [2], m_done_e [2];
    logic [AW-1:0] m_taddr [2];
    logic [DW-1:0] m_twd [2];
    logic          e_rdy [2], e_rdv [2], e_cs [2], e_we [2], e_err [2];
    logic [DW-1:0] e_rdata [2], e_wd [2];
    logic [AW-1:0] e_addr [2];
    logic [15:0]   e_wc [2], e_rc [2];

    task automatic model_edge();
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                m_busy[i] = 1'b0;  e_rdy[i] = 1'b1;  e_rdv[i] = 1'b0;  e_rdata[i] = '0;
                e_cs[i] = 1'b0;    e_we[i] = 1'b0;   e_addr[i] = '0;   e_wd[i] = '0;
                e_wc[i] = 16'd0;   e_rc[i] = 16'd0;  e_err[i] = 1'b0;
            end else begin
                e_rdv[i] = 1'b0;
                e_cs[i]  = 1'b0;
                e_we[i]  = 1'b0;
                if (!m_busy[i] && (bus_rd || bus_wr)) begin
                    m_busy[i]  = 1'b1;
                    m_isrd[i]  = bus_rd;
                    m_taddr[i] = bus_addr;
                    m_twd[i]   = bus_wdata;
                    m_oor[i]   = oor(i, bus_addr);
                    if ((bus_rd && bus_wr) || m_oor[i]) e_err[i] = 1'b1;
                    m_cs_e[i]   = edge_n + cfg_w(i);
                    m_done_e[i] = m_isrd[i] ? m_cs_e[i] + cfg_l(i) : m_cs_e[i] + 1;
                end
                if (m_busy[i] && edge_n == m_cs_e[i]) begin
                    if (!m_oor[i]) begin
                        e_cs[i] = 1'b1;  e_we[i] = !m_isrd[i];
                        e_addr[i] = m_taddr[i];  e_wd[i] = m_twd[i];
                    end
                    if (m_isrd[i]) e_rc[i] = sat16(e_rc[i]);
                    else           e_wc[i] = sat16(e_wc[i]);
                end
                if (m_busy[i] && edge_n == m_done_e[i]) begin
                    m_busy[i] = 1'b0;
                    if (m_isrd[i]) begin
                        e_rdv[i]   = 1'b1;
                        e_rdata[i] = m_oor[i] ? 8'hFF : rom(m_taddr[i]);
                    end
                end
                e_rdy[i] = !m_busy[i];
            end
        end
    endtask

    // Per-cycle compare on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    check("bus_ready", i, 32'(rdy[i]), 32'(e_rdy[i]));
                    check("bus_rdata_ready", i, 32'(rdv[i]), 32'(e_rdv[i]));
                    check("bus_rdata", i, 32'(rdata[i]), 32'(e_rdata[i]));
                    check("mem_cs", i, 32'(cs[i]), 32'(e_cs[i]));
                    check("mem_we", i, 32'(we[i]), 32'(e_we[i]));
                    check("mem_addr", i, 32'(maddr[i]), 32'(e_addr[i]));
                    check("mem_wdata", i, 32'(mwd[i]), 32'(e_wd[i]));
                    check("wr_cnt", i, 32'(wc[i]), 32'(e_wc[i]));
                    check("rd_cnt", i, 32'(rc[i]), 32'(e_rc[i]));
                    check("err_flag", i, 32'(err[i]), 32'(e_err[i]));
                end
            end
        end
    end

    // Inputs change 1ns after the rising edge; outputs are then stable for literal checks.
    task automatic step(input logic r, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rstn = r;  bus_rd = rd;  bus_wr = wr;  bus_addr = a;  bus_wdata = d;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    int pulse_a, pulse_b, cs_b, busy_b;
    logic [15:0] wc_before;

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check("rst_ready", 0, 32'(rdy[0]), 32'd1);
        check("rst_cs", 0, 32'(cs[0]), 32'd0);
        check("rst_wr_cnt", 0, 32'(wc[0]), 32'd0);

        // Single write: SRAM strobe in the cycle after accept, ready back one cycle later.
        step(1'b1, 1'b0, 1'b1, 17'h00010, 8'hA5);
        check("wr_cs", 0, 32'(cs[0]), 32'd1);
        check("wr_we", 0, 32'(we[0]), 32'd1);
        check("wr_addr", 0, 32'(maddr[0]), 32'h10);
        check("wr_data", 0, 32'(mwd[0]), 32'hA5);
        check("wr_cnt1", 0, 32'(wc[0]), 32'd1);
        check("wr_busy", 0, 32'(rdy[0]), 32'd0);
        idle(1);
        check("wr_ready_back", 0, 32'(rdy[0]), 32'd1);
        idle(8);

        // Read with write pulses hammering the busy window of instance b.
        step(1'b1, 1'b1, 1'b0, 17'h00010, 8'h00);
        pulse_a = -1;  pulse_b = -1;  cs_b = 0;  busy_b = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, (k % 2 == 0), 17'h00055, 8'(k));
            if (rdv[0] === 1'b1 && pulse_a < 0) begin
                pulse_a = k;
                check("rd_a_data", 0, 32'(rdata[0]), 32'h3C);
            end
            if (rdv[1] === 1'b1 && pulse_b < 0) begin
                pulse_b = k;
                check("rd_b_data", 1, 32'(rdata[1]), 32'h3C);
            end
            if (k <= 6 && rdy[1] === 1'b0) busy_b++;
            if (k <= 7 && cs[1] === 1'b1) cs_b++;
        end
        check("rd_a_latency", 0, 32'(pulse_a), 32'd2);
        check("rd_b_latency", 1, 32'(pulse_b), 32'd7);
        check("rd_b_busy_cycles", 1, 32'(busy_b), 32'd6);
        check("rd_b_cs_count", 1, 32'(cs_b), 32'd1);
        check("rd_a_cnt", 0, 32'(rc[0]), 32'd1);
        idle(10);

        // Simultaneous read and write behaves as a read and raises the sticky error.
        wc_before = e_wc[0];
        step(1'b1, 1'b1, 1'b1, 17'h00020, 8'h77);
        check("rw_cs", 0, 32'(cs[0]), 32'd1);
        check("rw_we", 0, 32'(we[0]), 32'd0);
        check("rw_err", 0, 32'(err[0]), 32'd1);
        idle(3);
        check("rw_rdata", 0, 32'(rdata[0]), 32'h7A);
        check("rw_wr_cnt", 0, 32'(wc[0]), 32'(wc_before));
        idle(10);
        check("rw_err_sticky", 0, 32'(err[0]), 32'd1);

        // Reset at the edge that would have produced the read pulse.
        step(1'b1, 1'b1, 1'b0, 17'h00030, 8'h00);
        idle(1);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check("rst_rdv", 0, 32'(rdv[0]), 32'd0);
        check("rst_ready2", 0, 32'(rdy[0]), 32'd1);
        check("rst_rdata", 0, 32'(rdata[0]), 32'd0);
        check("rst_err", 0, 32'(err[0]), 32'd0);
        check("rst_rd_cnt", 0, 32'(rc[0]), 32'd0);
        idle(4);

        // Read beyond a 1024-word SRAM.
        step(1'b1, 1'b1, 1'b0, 17'h00400, 8'h00);
`ifdef SDIO_BUS_ADDR_CHK_EN
        check("oor_cs", 0, 32'(cs[0]), 32'd0);
`else
        check("oor_cs", 0, 32'(cs[0]), 32'd1);
`endif
        idle(2);
        check("oor_rdv", 0, 32'(rdv[0]), 32'd1);
`ifdef SDIO_BUS_ADDR_CHK_EN
        check("oor_rdata", 0, 32'(rdata[0]), 32'hFF);
        check("oor_err", 0, 32'(err[0]), 32'd1);
`else
        check("oor_rdata", 0, 32'(rdata[0]), 32'h5E);
        check("oor_err", 0, 32'(err[0]), 32'd0);
`endif
        idle(10);

        // 65540 back-to-back writes saturate the write counter.
        for (int k = 0; k < 131080; k++) step(1'b1, 1'b0, 1'b1, AW'(k % 256), 8'(k));
        idle(2);
        check("wr_cnt_sat", 0, 32'(wc[0]), 32'hFFFF);
        idle(10);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
